// File: rtl/conv_pkg.sv
// Shared window geometry for the convolution datapath: kernel size, slot
// numbering and the default pixel type.
package conv_pkg;

    localparam int unsigned K     = 5;
    localparam int unsigned WIN_N = K * K;
    localparam int unsigned PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // Slot k of the window holds pixel (top + k/K, left + k%K).
    function automatic int unsigned slot(input int unsigned r, input int unsigned c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of the window generator. The master side feeds
// pixels and consumes windows; the slave side is the generator itself.
interface conv_window_gen_if #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned DW    = 8
);
    import conv_pkg::*;

    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_pix;
    logic                  win_valid;
    logic                  win_ready;
    logic [WIN_N*DW-1:0]   win_pix;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;
    logic                  win_last;

    modport master (
        output in_valid, in_pix, win_ready,
        input  in_ready, win_valid, win_pix, win_row, win_col, win_last
    );

    modport slave (
        input  in_valid, in_pix, win_ready,
        output in_ready, win_valid, win_pix, win_row, win_col, win_last
    );

endinterface

// File: rtl/conv_line_buf.sv
// One image row of circular storage; combinational read-before-write at a
// shared column address so the old row is available in the write cycle.
module conv_line_buf #(
    parameter  int unsigned DEPTH = 28,
    parameter  int unsigned W     = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    // Contents need no reset: a new frame rewrites every row before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 sliding-window generator: raster pixels in, one complete
// window per valid stride-1 output position out, in PE slot order.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    conv_window_gen_if.slave  bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WW    = WIN_N * DW;
    localparam int unsigned LB_W  = (K - 1) * DW;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WW-1:0]    win_q, win_d;
    logic             out_valid_q, out_valid_d;
    logic [WW-1:0]    out_pix_q, out_pix_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic             emit;
    logic [LB_W-1:0]  lb_rdata;
    logic [LB_W-1:0]  lb_wdata;
    logic [K*DW-1:0]  col_vec;

    // Four rows packed side by side: lane 0 = row-1 ... lane 3 = row-4.
    conv_line_buf #(
        .DEPTH (IMG_W),
        .W     (LB_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    assign bus.in_ready  = !out_valid_q || bus.win_ready;
    assign bus.win_valid = out_valid_q;
    assign bus.win_pix   = out_pix_q;
    assign bus.win_row   = out_row_q;
    assign bus.win_col   = out_col_q;
    assign bus.win_last  = out_last_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign emit     = accept && (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
    assign lb_wdata = {lb_rdata[LB_W-DW-1:0], bus.in_pix};

    // Incoming column, top window row first; the live pixel is the bottom row.
    always_comb begin
        col_vec = '0;
        for (int r = 0; r < int'(K) - 1; r++) begin
            col_vec[r*DW +: DW] = lb_rdata[(int'(K) - 2 - r)*DW +: DW];
        end
        col_vec[(K-1)*DW +: DW] = bus.in_pix;
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;

        if (bus.win_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            for (int r = 0; r < int'(K); r++) begin
                for (int c = 0; c < int'(K) - 1; c++) begin
                    win_d[slot(r, c)*DW +: DW] = win_q[slot(r, c + 1)*DW +: DW];
                end
                win_d[slot(r, K - 1)*DW +: DW] = col_vec[r*DW +: DW];
            end
        end

        // The output register takes the window including the column just shifted in.
        if (emit) begin
            out_valid_d = 1'b1;
            out_pix_d   = win_d;
            out_row_d   = row_q - ROW_W'(K - 1);
            out_col_d   = col_q - COL_W'(K - 1);
            out_last_d  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: 8x8 frames with stalls, gaps,
// back-to-back frames and mid-frame reset, plus a 5x5 single-window instance.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int unsigned WW = WIN_N * PIX_W;

    typedef struct {
        logic [WW-1:0] pix;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_window_gen_if #(.IMG_W(8), .IMG_H(8), .DW(8)) b8 ();
    conv_window_gen_if #(.IMG_W(5), .IMG_H(5), .DW(8)) b5 ();

    conv_window_gen #(.IMG_W(8), .IMG_H(8), .DW(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(5), .DW(8)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   win_cnt = 0;
    bit   stall_req = 1'b0;
    int   f_idx = -1;
    logic [7:0] f0, f24;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window whose bottom-right pixel is (r,c) in a w-wide frame of base+r*w+c pixels.
    function automatic logic [WW-1:0] exp_win(input int w, input logic [7:0] base, input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] p;
            p = base + 8'((r - 4 + k / 5) * w + (c - 4 + k % 5));
            v[k*8 +: 8] = p;
        end
        return v;
    endfunction

    // Scoreboard pop on every window transfer of the 8x8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst && b8.win_valid && b8.win_ready) begin
            chk("sb_nonempty", WW'(sb.size() != 0), WW'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("win_pix",  b8.win_pix, e.pix);
                chk("win_row",  WW'(b8.win_row), WW'(e.row));
                chk("win_col",  WW'(b8.win_col), WW'(e.col));
                chk("win_last", WW'(b8.win_last), WW'(e.last));
                if (win_cnt == f_idx) begin
                    chk("spot_slot0",  WW'(b8.win_pix[7:0]), WW'(f0));
                    chk("spot_slot24", WW'(b8.win_pix[199:192]), WW'(f24));
                end
                win_cnt++;
            end
        end
    end

    // Consumer: always ready, except a 10-cycle stall at the first window when requested.
    initial begin
        logic [WW-1:0] hold;
        b8.win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_req && b8.win_valid && sb.size() != 0) begin
                stall_req    = 1'b0;
                hold         = sb[0].pix;
                b8.win_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  WW'(b8.in_ready), WW'(0));
                    chk("stall_win_valid", WW'(b8.win_valid), WW'(1));
                    chk("stall_hold",      b8.win_pix, hold);
                    if (i != 9) begin
                        @(posedge clk); #1;
                    end
                end
                @(posedge clk); #1;
                b8.win_ready = 1'b1;
            end
        end
    end

    task automatic drive_frame(input logic [7:0] base, input int npix, input bit gaps);
        int r = 0;
        int c = 0;
        int n = 0;
        int guard = 0;
        while (n < npix && guard < 5000) begin
            @(posedge clk); #1;
            b8.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            b8.in_pix   = base + 8'(r * 8 + c);
            @(negedge clk);
            guard++;
            if (b8.in_valid && b8.in_ready) begin
                if (r >= 4 && c >= 4) begin
                    sb.push_back('{exp_win(8, base, r, c), r - 4, c - 4, (r == 7 && c == 7)});
                end
                n++;
                c++;
                if (c == 8) begin
                    c = 0;
                    r = (r == 7) ? 0 : r + 1;
                end
            end
        end
        if (guard >= 5000) begin
            chk("drive_timeout", WW'(n), WW'(npix));
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int exp_cnt);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_drain"}, WW'(sb.size()), '0);
        chk({tag, "_count"}, WW'(win_cnt), WW'(exp_cnt));
        chk({tag, "_idle"},  WW'(b8.win_valid), WW'(0));
        win_cnt = 0;
        f_idx   = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  WW'(b8.in_ready), WW'(1));
        chk({tag, "_win_valid"}, WW'(b8.win_valid), WW'(0));
        chk({tag, "_win_pix"},   b8.win_pix, '0);
        chk({tag, "_win_row"},   WW'(b8.win_row), WW'(0));
        chk({tag, "_win_col"},   WW'(b8.win_col), WW'(0));
        chk({tag, "_win_last"},  WW'(b8.win_last), WW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        b8.in_valid = 1'b0;
        b8.in_pix   = '0;
        b5.in_valid = 1'b0;
        b5.in_pix   = '0;
        b5.win_ready = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Gapless frame, consumer always ready.
        f_idx = 0; f0 = 8'h00; f24 = 8'h24;
        drive_frame(8'h00, 64, 1'b0);
        go_idle();
        wait_drain("t1", 16);

        // Consumer stall at the first window.
        stall_req = 1'b1;
        drive_frame(8'h00, 64, 1'b0);
        go_idle();
        wait_drain("t2", 16);

        // Random input gaps.
        drive_frame(8'h00, 64, 1'b1);
        go_idle();
        wait_drain("t3", 16);

        // Two frames with no idle cycle between them.
        f_idx = 16; f0 = 8'h80; f24 = 8'hA4;
        drive_frame(8'h00, 64, 1'b0);
        drive_frame(8'h80, 64, 1'b0);
        go_idle();
        wait_drain("t4", 32);

        // Reset pulse after 40 pixels, then a full frame.
        drive_frame(8'h00, 40, 1'b0);
        go_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        chk("midrst_partial_count", WW'(win_cnt), WW'(4));
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        win_cnt = 0;
        drive_frame(8'h00, 64, 1'b0);
        go_idle();
        wait_drain("t5", 16);

        // 5x5 image: exactly one window per frame.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 25; i++) begin
                @(posedge clk); #1;
                b5.in_valid = 1'b1;
                b5.in_pix   = 8'(f * 64 + i);
                @(negedge clk);
                chk("w5_early_valid", WW'(b5.win_valid), WW'(0));
            end
            @(posedge clk); #1;
            b5.in_valid = 1'b0;
            @(negedge clk);
            chk("w5_valid", WW'(b5.win_valid), WW'(1));
            chk("w5_pix",   b5.win_pix, exp_win(5, 8'(f * 64), 4, 4));
            chk("w5_row",   WW'(b5.win_row), WW'(0));
            chk("w5_col",   WW'(b5.win_col), WW'(0));
            chk("w5_last",  WW'(b5.win_last), WW'(1));
            @(posedge clk); #1;
            @(negedge clk);
            chk("w5_consumed", WW'(b5.win_valid), WW'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 5x5 sliding-window generator that feeds the convolution PE. It accepts one unsigned 8-bit feature-map pixel per cycle in raster order and buffers four image rows internally. For every valid (stride-1, no padding) output position it presents the 25-pixel window in the exact slot order the PE expects on its IF1..IF25 inputs. It sits between the feature-map buffer reader and the PE array, and is the producer side of the PE's window interface.

## Interface
Parameters:
- IMG_W, 28, image width in pixels (>= 5)
- IMG_H, 28, image height in pixels (>= 5)
- DW, 8, pixel width (unsigned)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  1  in_pix is valid
- in_ready  out  1  block accepts in_pix this cycle
- in_pix  in  DW  pixel, raster order, row 0 col 0 first
- win_valid  out  1  win_pix holds a complete window
- win_ready  in  1  consumer takes the window this cycle
- win_pix  out  25*DW  window; slot k (0..24) = bits [k*DW +: DW] = pixel (top+k/5, left+k%5); slot k drives PE IF(k+1)
- win_row  out  clog2(IMG_H)  output row index (top row of window)
- win_col  out  clog2(IMG_W)  output column index (left column of window)
- win_last  out  1  window is the last of the frame, i.e. (IMG_H-5, IMG_W-5)

## Operation
- Accept = in_valid && in_ready; only accepted pixels advance any state.
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) track the incoming pixel. col wraps to 0 at IMG_W-1 and increments row. Both wrap to 0 after (IMG_H-1, IMG_W-1); the next accepted pixel starts a new frame with no idle cycle.
- Four line buffers, each IMG_W deep, hold rows row-4..row-1 at column col. On accept, the new pixel and four buffer reads form a 5-pixel column that is shifted into a 5x5 register window (new column enters at the right, slots 4/9/14/19/24). The buffers shift down one row.
- Window emit condition: accepted pixel has row >= 4 and col >= 4. The output register then loads the window, win_row = row-4, win_col = col-4, and win_last = (row==IMG_H-1 && col==IMG_W-1).
- Windows with col < 4 contain previous-row pixels; they are never emitted. Line buffers are not cleared between frames.
- Output register holds one window. in_ready = !win_valid || win_ready, so backpressure from the PE stalls input intake with no data loss.
- Window count per frame is (IMG_H-4)*(IMG_W-4).
- Reset (rst=0) at any time: counters to 0, win_valid=0, window and output registers to 0; a partial frame is discarded. The first pixel after release is (0,0).

## Timing
- Reset values: in_ready=1 (follows win_valid=0), win_valid=0, win_pix=0, win_row=0, win_col=0, win_last=0.
- Latency: an emitting pixel accepted in cycle t gives win_valid=1 in cycle t+1.
- win_valid stays high and all win_* outputs stay stable until win_ready=1. Simultaneous win_ready and an emitting accept reload the register in the same edge, giving full throughput of 1 window/cycle.
- in_ready is combinational from win_valid/win_ready. No combinational path from in_valid to any output.
- Line buffer read must return data in the accept cycle. Use a registered-address or pre-fetched read so the next column is available; no extra bubble.

## Structure
- Shared package conv_pkg: K=5, WIN_N=25, slot index function slot(r,c)=r*K+c, pixel typedef of DW bits.
- One sub-module: conv_line_buf. It is a single-row IMG_W-deep circular buffer with read-before-write at a shared column address, instantiated 4x, or once with 4*DW width.

## Test plan
- IMG_W=IMG_H=8, pix=(r*8+c)&0xFF, in_valid always 1, win_ready=1. The first win_valid comes one cycle after pixel 36 is accepted, with slots 0..24 = {0,1,2,3,4,8,...,36}. Expect 16 windows; the last has win_row=3, win_col=3, slot0=27, slot24=63, win_last=1.
- Same frame with win_ready=0 for 10 cycles at the first window. Expect in_ready=0 and win_pix held constant. On release the window sequence is identical with no loss or duplication.
- Random in_valid gaps (50%) → same 16 windows in same order and values as the gapless run.
- Two back-to-back 8x8 frames, second frame pix=(0x80+r*8+c). The second frame's first window has slot0=0x80, slot24=0xA4, and no window is emitted from mixed-frame columns.
- Reset pulse (rst=0 for 1 cycle) after pixel 40 of a frame. All outputs return to reset values and the restarted frame yields the full 16 correct windows.
- IMG_W=IMG_H=5 → exactly one window per frame, win_row=0, win_col=0, win_last=1.
